uart_rx_buffer: RTL and testbench

Receive-side buffer that sits directly downstream of the UART byte receiver. It completes the receiver's four-phase ready/valid acknowledge for every byte and stores the bytes in a first-word-fall-through FIFO. The FIFO is presented to the consuming logic (command parser, SPI bridge, etc.) as a simple valid/ready byte stream. This decouples consumer latency from the line rate, so the receiver returns to idle within a few clocks of each stop bit.

---
 rtl/uart_defs_pkg.sv | 25 ++
 rtl/byte_fifo.sv | 64 ++++++
 rtl/uart_rx_buffer.sv | 118 +++++++++++
 tb/tb_uart_rx_buffer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_defs (package)
//  Description : Definitions shared by the UART receiver, transmitter and
//                receive buffer: byte width, default buffer depth and the
//                acknowledge-FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_defs;

    // Width of one UART data byte, common to receiver and transmitter.
    localparam int c_byte_w = 8;

    // Default receive-buffer depth: 2^4 = 16 bytes.
    localparam int c_default_depth_log2 = 4;

    // Four-phase acknowledge states, 2-bit encoding.
    typedef enum logic [1:0] {
        ACK_IDLE    = 2'd0,
        ACK_HOLD    = 2'd1,
        ACK_RELEASE = 2'd2
    } ack_state_e;

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : byte_fifo
//  Description : Synchronous first-word-fall-through byte FIFO. Pointers are
//                one bit wider than the address so full and empty can be
//                told apart; a push while full is accepted only when a pop
//                frees the head slot in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo
    import uart_defs::*;
#(
    parameter int DEPTH_LOG2 = c_default_depth_log2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_push,
    input  logic [c_byte_w-1:0]   i_push_data,
    input  logic                  i_pop,
    output logic [c_byte_w-1:0]   o_head,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam int                  c_depth   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_ptr_one = 1;

    logic [c_byte_w-1:0]  r_mem [c_depth];
    logic [DEPTH_LOG2:0]  r_wr_ptr;
    logic [DEPTH_LOG2:0]  r_rd_ptr;
    logic                 w_push_ok;
    logic                 w_pop_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                       (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_head    = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

    // A pop in the same cycle frees the slot, so a push at full is still legal.
    assign w_push_ok = i_push && (!o_full || i_pop);
    assign w_pop_ok  = i_pop && !o_empty;

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_push_data;
        end
    end

    // Pointer update; both pointers wrap naturally through the extra MSB.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_buffer
//  Description : Receive-side buffer behind the UART byte receiver. Completes
//                the receiver's four-phase valid/ready acknowledge for every
//                byte and queues the bytes in a FWFT FIFO presented to the
//                consumer as a valid/ready byte stream.
//                Build option UART_RX_BUF_BACKPRESSURE_EN: when defined, a
//                full buffer withholds the acknowledge instead of discarding
//                the byte (o_overflow then never sets).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_buffer
    import uart_defs::*;
#(
    parameter int DEPTH_LOG2 = c_default_depth_log2
) (
    input  logic                  i_uart_clk,
    input  logic                  i_reset,
    input  logic [c_byte_w-1:0]   i_rx_byte,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    output logic [c_byte_w-1:0]   o_data,
    output logic                  o_data_valid,
    input  logic                  i_data_ready,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_overflow,
    input  logic                  i_overflow_clr
);

    ack_state_e r_state;
    ack_state_e w_state_next;
    logic       r_rx_ready;
    logic       r_overflow;
    logic       w_push;
    logic       w_discard;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic       w_room;

    assign o_data_valid = !w_empty;
    assign w_pop        = o_data_valid && i_data_ready;
    assign w_room       = !w_full || w_pop;
    assign o_rx_ready   = r_rx_ready;
    assign o_overflow   = r_overflow;

    // Acknowledge FSM next state: one write per valid assertion, taken on entry to HOLD.
    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_discard    = 1'b0;
        case (r_state)
            ACK_IDLE: begin
                if (i_rx_valid) begin
`ifdef UART_RX_BUF_BACKPRESSURE_EN
                    if (w_room) begin
                        w_push       = 1'b1;
                        w_state_next = ACK_HOLD;
                    end
`else
                    // Always acknowledge so the receiver can return to idle.
                    w_state_next = ACK_HOLD;
                    if (w_room) w_push    = 1'b1;
                    else        w_discard = 1'b1;
`endif
                end
            end
            ACK_HOLD: begin
                if (!i_rx_valid) w_state_next = ACK_RELEASE;
            end
            ACK_RELEASE: begin
                w_state_next = ACK_IDLE;
            end
            default: begin
                w_state_next = ACK_IDLE;
            end
        endcase
    end

    // State register plus a true register for ready, high exactly in HOLD.
    always_ff @(posedge i_uart_clk) begin
        if (i_reset) begin
            r_state    <= ACK_IDLE;
            r_rx_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rx_ready <= (w_state_next == ACK_HOLD);
        end
    end

    // Sticky overflow flag; a discard outranks a same-cycle clear.
    always_ff @(posedge i_uart_clk) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
        end else if (w_discard) begin
            r_overflow <= 1'b1;
        end else if (i_overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .i_clk       (i_uart_clk),
        .i_reset     (i_reset),
        .i_push      (w_push),
        .i_push_data (i_rx_byte),
        .i_pop       (w_pop),
        .o_head      (o_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (o_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_buffer
//  Description : Self-checking bench for uart_rx_buffer. A four-phase
//                receiver model drives bytes in; a queue-based reference
//                model holds the expected FIFO contents and overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_buffer;

    localparam int c_dl    = 4;
    localparam int c_depth = 1 << c_dl;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     rx_byte = 8'h00;
    logic           rx_valid = 1'b0;
    logic           rx_ready;
    logic [7:0]     data;
    logic           data_valid;
    logic           data_ready = 1'b0;
    logic [c_dl:0]  count;
    logic           overflow;
    logic           ovf_clr = 1'b0;

    int             n_cmp = 0;
    int             n_err = 0;
    logic [7:0]     q[$];
    logic           m_ovf = 1'b0;

    uart_rx_buffer #(.DEPTH_LOG2(c_dl)) dut (
        .i_uart_clk     (clk),
        .i_reset        (rst),
        .i_rx_byte      (rx_byte),
        .i_rx_valid     (rx_valid),
        .o_rx_ready     (rx_ready),
        .o_data         (data),
        .o_data_valid   (data_valid),
        .i_data_ready   (data_ready),
        .o_count        (count),
        .o_overflow     (overflow),
        .i_overflow_clr (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Compare all consumer-side outputs with the reference queue.
    task automatic chk_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".valid"}, 32'(data_valid), 32'(q.size() != 0));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        if (q.size() != 0) chk({tag, ".head"}, 32'(data), 32'(q[0]));
    endtask

    task automatic model_push(input logic [7:0] b);
        if (q.size() < c_depth) q.push_back(b);
        else                    m_ovf = 1'b1;
    endtask

    // Receiver model: full four-phase handshake, valid held 'extra' cycles after ack.
    task automatic send_byte(input logic [7:0] b, input int extra);
        int w;
        rx_byte  = b;
        rx_valid = 1'b1;
        w = 0;
        do begin
            tick;
            w++;
        end while (!rx_ready && w < 50);
        chk("ack_rise", 32'(rx_ready), 32'd1);
        model_push(b);
        for (int i = 0; i < extra; i++) begin
            tick;
            chk("ack_hold", 32'(rx_ready), 32'd1);
        end
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
        tick;
        chk("ack_release", 32'(rx_ready), 32'd0);
        tick;
        chk("ack_idle", 32'(rx_ready), 32'd0);
    endtask

    task automatic pop_one(input string tag);
        chk({tag, ".pre_valid"}, 32'(data_valid), 32'd1);
        if (q.size() != 0) chk({tag, ".pre_data"}, 32'(data), 32'(q[0]));
        data_ready = 1'b1;
        tick;
        data_ready = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        chk_state(tag);
    endtask

    initial begin
        logic [7:0] b;
        int         guard;
        logic       popped;

        // Reset state
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        chk("reset.ready", 32'(rx_ready), 32'd0);
        chk_state("reset");

        // Single byte
        send_byte(8'hA5, 0);
        chk_state("single");
        chk("single.data", 32'(data), 32'h0A5);
        pop_one("single_pop");

        // Long valid hold: exactly one write
        b = 8'($urandom);
        send_byte(b, 20);
        chk("long.count", 32'(count), 32'd1);
        pop_one("long_pop");

        // Fill and wrap
        for (int i = 0; i < 16; i++) send_byte(8'(i), int'($urandom_range(0, 2)));
        chk_state("fill");
        for (int i = 0; i < 8; i++) pop_one("wrap_pop");
        for (int i = 16; i < 24; i++) send_byte(8'(i), 0);
        chk("wrap.count", 32'(count), 32'd16);
        chk("wrap.head", 32'(data), 32'h08);
        chk_state("wrap");

`ifdef UART_RX_BUF_BACKPRESSURE_EN
        // Backpressure: ack withheld while full, released by a pop
        rx_byte  = 8'hEE;
        rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("bp.ready_low", 32'(rx_ready), 32'd0);
        end
        chk_state("bp_full");
        data_ready = 1'b1;
        tick;
        data_ready = 1'b0;
        void'(q.pop_front());
        q.push_back(8'hEE);
        chk("bp.ready_rise", 32'(rx_ready), 32'd1);
        chk_state("bp_after");
        rx_valid = 1'b0;
        tick;
        tick;
        chk("bp.ready_idle", 32'(rx_ready), 32'd0);
`else
        // Overflow: ack still pulses, byte discarded
        send_byte(8'hEE, 0);
        chk_state("ovf");
        ovf_clr = 1'b1;
        tick;
        ovf_clr = 1'b0;
        m_ovf = 1'b0;
        chk_state("ovf_clr");
        // Set and clear in the same cycle: set wins
        rx_byte  = 8'hEE;
        rx_valid = 1'b1;
        ovf_clr  = 1'b1;
        tick;
        ovf_clr  = 1'b0;
        m_ovf    = 1'b1;
        chk("ovf_win.ready", 32'(rx_ready), 32'd1);
        chk_state("ovf_win");
        rx_valid = 1'b0;
        tick;
        tick;
        ovf_clr = 1'b1;
        tick;
        ovf_clr = 1'b0;
        m_ovf = 1'b0;
        chk_state("ovf_clr2");
`endif

        // Simultaneous push and pop at full
        chk("sim.full_count", 32'(count), 32'd16);
        b = 8'($urandom);
        rx_byte    = b;
        rx_valid   = 1'b1;
        data_ready = 1'b1;
        tick;
        data_ready = 1'b0;
        void'(q.pop_front());
        q.push_back(b);
        chk("sim.ready", 32'(rx_ready), 32'd1);
        chk_state("sim");
        rx_valid = 1'b0;
        tick;
        tick;

        // Drain with a random consumer ready pattern
        guard = 0;
        while (q.size() != 0 && guard < 400) begin
            data_ready = 1'($urandom_range(0, 1));
            popped = data_ready;
            tick;
            data_ready = 1'b0;
            if (popped) void'(q.pop_front());
            chk_state("drain");
            guard++;
        end
        chk("drain.timeout", 32'(guard < 400), 32'd1);

        // Random mix of sends and pops
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) != 0) begin
`ifdef UART_RX_BUF_BACKPRESSURE_EN
                if (q.size() < c_depth) send_byte(8'($urandom), int'($urandom_range(0, 3)));
`else
                send_byte(8'($urandom), int'($urandom_range(0, 3)));
`endif
            end else if (q.size() != 0) begin
                pop_one("rand_pop");
            end
            chk_state("rand");
        end

        // Reset during HOLD with three bytes buffered
        while (q.size() != 0) pop_one("pre_rst_pop");
        send_byte(8'($urandom), 0);
        send_byte(8'($urandom), 0);
        b = 8'($urandom);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick;
        q.push_back(b);
        chk("rst_hold.ready", 32'(rx_ready), 32'd1);
        chk("rst_hold.count", 32'(count), 32'd3);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        chk("rst_mid.ready", 32'(rx_ready), 32'd0);
        chk_state("rst_mid");
        tick;
        q.push_back(b);
        chk("recapture.ready", 32'(rx_ready), 32'd1);
        chk_state("recapture");
        rx_valid = 1'b0;
        tick;
        tick;
        chk("recapture.idle", 32'(rx_ready), 32'd0);
        pop_one("final_pop");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
